// File: rtl/operand_collector.sv
// Operand collector: accepts one dispatched instruction, reads its register operands from the
// register file one at a time, then holds the completed instruction until the EU takes it.
package bgpu_pkg;
   typedef struct packed {
      logic [5:0] opcode;
      logic [1:0] fmt;
   } inst_t;
endpackage

module operand_collector #(
   parameter  int PcWidth         = 32,
   parameter  int NumWarps        = 8,
   parameter  int WarpWidth       = 32,
   parameter  int NumTags         = 8,
   parameter  int RegIdxWidth     = 6,
   parameter  int OperandsPerInst = 2,
   parameter  int RegWidth        = 32,
   localparam int TagWidth        = $clog2(NumTags),
   localparam int WidWidth        = NumWarps > 1 ? $clog2(NumWarps) : 1,
   localparam int IidWidth        = TagWidth + WidWidth
) (
   input  logic                                         clk_i,
   input  logic                                         rst_i,
   output logic                                         opc_ready_o,
   input  logic                                         disp_valid_i,
   input  logic [IidWidth-1:0]                          disp_tag_i,
   input  logic [PcWidth-1:0]                           disp_pc_i,
   input  logic [WarpWidth-1:0]                         disp_act_mask_i,
   input  bgpu_pkg::inst_t                              disp_inst_i,
   input  logic [RegIdxWidth-1:0]                       disp_dst_i,
   input  logic [OperandsPerInst-1:0]                   disp_operands_is_reg_i,
   input  logic [OperandsPerInst*RegIdxWidth-1:0]       disp_operands_i,
   output logic                                         rf_req_valid_o,
   input  logic                                         rf_req_ready_i,
   output logic [WidWidth-1:0]                          rf_req_wid_o,
   output logic [RegIdxWidth-1:0]                       rf_req_reg_o,
   input  logic                                         rf_rsp_valid_i,
   input  logic [WarpWidth*RegWidth-1:0]                rf_rsp_data_i,
   output logic                                         eu_valid_o,
   input  logic                                         eu_ready_i,
   output logic [IidWidth-1:0]                          eu_tag_o,
   output logic [PcWidth-1:0]                           eu_pc_o,
   output logic [WarpWidth-1:0]                         eu_act_mask_o,
   output bgpu_pkg::inst_t                              eu_inst_o,
   output logic [RegIdxWidth-1:0]                       eu_dst_o,
   output logic [OperandsPerInst*WarpWidth*RegWidth-1:0] eu_operands_o,
   output logic                                         opc_eu_handshake_o,
   output logic [IidWidth-1:0]                          opc_eu_tag_o
);
   localparam int SlotWidth  = WarpWidth * RegWidth;
   localparam int OpIdxWidth = OperandsPerInst > 1 ? $clog2(OperandsPerInst) : 1;

   // Handshakes: a transfer happens on a rising clock edge where valid and ready are both high;
   // valid never depends combinationally on ready and, once raised, holds with stable payload.
   typedef enum logic [1:0] {IDLE, READ, ISSUE} state_t;
   state_t state_q, state_d;

   logic [IidWidth-1:0]                         tag_q;
   logic [PcWidth-1:0]                          pc_q;
   logic [WarpWidth-1:0]                        mask_q;
   bgpu_pkg::inst_t                             inst_q;
   logic [RegIdxWidth-1:0]                      dst_q;
   logic [OperandsPerInst-1:0]                  is_reg_q;
   logic [OperandsPerInst-1:0][RegIdxWidth-1:0] opnd_q;
   logic [OperandsPerInst-1:0][SlotWidth-1:0]   slots_q;
   logic [OpIdxWidth-1:0]                       cur_q;
   logic                                        outst_q;

   logic                  next_found;
   logic [OpIdxWidth-1:0] next_idx;
   logic [OpIdxWidth-1:0] first_idx;

   // Lowest-indexed register operand after the current one, and the first one of a new dispatch.
   always_comb begin
      next_found = 1'b0;
      next_idx   = '0;
      first_idx  = '0;
      for (int i = OperandsPerInst - 1; i >= 0; i--) begin
         if (is_reg_q[i] && (i > int'(cur_q))) begin
            next_found = 1'b1;
            next_idx   = OpIdxWidth'(i);
         end
         if (disp_operands_is_reg_i[i]) first_idx = OpIdxWidth'(i);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d        = state_q;
      opc_ready_o    = 1'b0;
      rf_req_valid_o = 1'b0;
      eu_valid_o     = 1'b0;
      case (state_q)
         IDLE: begin
            opc_ready_o = 1'b1;
            if (disp_valid_i) state_d = (|disp_operands_is_reg_i) ? READ : ISSUE;
         end
         READ: begin
            rf_req_valid_o = !outst_q;
            if (outst_q && rf_rsp_valid_i && !next_found) state_d = ISSUE;
         end
         ISSUE: begin
            eu_valid_o = 1'b1;
            if (eu_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tag_q    <= '0;
         pc_q     <= '0;
         mask_q   <= '0;
         inst_q   <= '0;
         dst_q    <= '0;
         is_reg_q <= '0;
         opnd_q   <= '0;
         slots_q  <= '0;
         cur_q    <= '0;
         outst_q  <= 1'b0;
      end else begin
         if (state_q == IDLE && disp_valid_i) begin
            tag_q    <= disp_tag_i;
            pc_q     <= disp_pc_i;
            mask_q   <= disp_act_mask_i;
            inst_q   <= disp_inst_i;
            dst_q    <= disp_dst_i;
            is_reg_q <= disp_operands_is_reg_i;
            opnd_q   <= disp_operands_i;
            cur_q    <= first_idx;
            outst_q  <= 1'b0;
            // Register slots are overwritten later by the read data.
            for (int i = 0; i < OperandsPerInst; i++)
               slots_q[i] <= {WarpWidth{RegWidth'(disp_operands_i[i*RegIdxWidth +: RegIdxWidth])}};
         end
         if (state_q == READ) begin
            if (rf_req_valid_o && rf_req_ready_i) outst_q <= 1'b1;
            if (outst_q && rf_rsp_valid_i) begin
               slots_q[cur_q] <= rf_rsp_data_i;
               outst_q        <= 1'b0;
               if (next_found) cur_q <= next_idx;
            end
         end
      end
   end

   // A response without an outstanding read (e.g. one in flight across a reset) is dropped.
   always @(posedge clk_i) begin
      assert (rst_i || !rf_rsp_valid_i || outst_q)
         else $warning("operand_collector: rf response with no read outstanding was ignored");
   end

   assign rf_req_wid_o       = tag_q[WidWidth-1:0];
   assign rf_req_reg_o       = opnd_q[cur_q];
   assign eu_tag_o           = tag_q;
   assign eu_pc_o            = pc_q;
   assign eu_act_mask_o      = mask_q;
   assign eu_inst_o          = inst_q;
   assign eu_dst_o           = dst_q;
   assign eu_operands_o      = slots_q;
   assign opc_eu_handshake_o = eu_valid_o & eu_ready_i;
   assign opc_eu_tag_o       = tag_q;
endmodule

// File: tb/tb_operand_collector.sv
// Directed bench for operand_collector: dispatch driver, register-file responder model,
// and an EU-side monitor that checks each issued instruction against an expected queue.
module tb_operand_collector;
   import bgpu_pkg::*;

   localparam int IidW  = 6;
   localparam int SlotW = 32 * 32;
   localparam int OpsW  = 2 * SlotW;

   typedef struct packed {
      logic [IidW-1:0] tag;
      logic [31:0]     pc;
      logic [31:0]     mask;
      inst_t           inst;
      logic [5:0]      dst;
      logic [OpsW-1:0] ops;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            opc_ready_o;
   logic            disp_valid_i;
   logic [IidW-1:0] disp_tag_i;
   logic [31:0]     disp_pc_i;
   logic [31:0]     disp_act_mask_i;
   inst_t           disp_inst_i;
   logic [5:0]      disp_dst_i;
   logic [1:0]      disp_operands_is_reg_i;
   logic [11:0]     disp_operands_i;
   logic            rf_req_valid_o;
   logic            rf_req_ready_i;
   logic [2:0]      rf_req_wid_o;
   logic [5:0]      rf_req_reg_o;
   logic            rf_rsp_valid_i;
   logic [SlotW-1:0] rf_rsp_data_i;
   logic            eu_valid_o;
   logic            eu_ready_i;
   logic [IidW-1:0] eu_tag_o;
   logic [31:0]     eu_pc_o;
   logic [31:0]     eu_act_mask_o;
   inst_t           eu_inst_o;
   logic [5:0]      eu_dst_o;
   logic [OpsW-1:0] eu_operands_o;
   logic            opc_eu_handshake_o;
   logic [IidW-1:0] opc_eu_tag_o;

   operand_collector dut (
      .clk_i(clk), .rst_i(rst), .opc_ready_o(opc_ready_o),
      .disp_valid_i(disp_valid_i), .disp_tag_i(disp_tag_i), .disp_pc_i(disp_pc_i),
      .disp_act_mask_i(disp_act_mask_i), .disp_inst_i(disp_inst_i), .disp_dst_i(disp_dst_i),
      .disp_operands_is_reg_i(disp_operands_is_reg_i), .disp_operands_i(disp_operands_i),
      .rf_req_valid_o(rf_req_valid_o), .rf_req_ready_i(rf_req_ready_i),
      .rf_req_wid_o(rf_req_wid_o), .rf_req_reg_o(rf_req_reg_o),
      .rf_rsp_valid_i(rf_rsp_valid_i), .rf_rsp_data_i(rf_rsp_data_i),
      .eu_valid_o(eu_valid_o), .eu_ready_i(eu_ready_i), .eu_tag_o(eu_tag_o), .eu_pc_o(eu_pc_o),
      .eu_act_mask_o(eu_act_mask_o), .eu_inst_o(eu_inst_o), .eu_dst_o(eu_dst_o),
      .eu_operands_o(eu_operands_o), .opc_eu_handshake_o(opc_eu_handshake_o),
      .opc_eu_tag_o(opc_eu_tag_o)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t exp_q[$];
   int   hs_count = 0;
   int   req_count = 0;
   bit   rf_auto = 1'b1;
   int   stale_req_n = 0;

   function automatic logic [31:0] rf_word(input logic [2:0] wid, input logic [5:0] r, input int t);
      logic [31:0] base;
      case (r)
         6'd4:    base = 32'hAAAA_0000;
         6'd7:    base = 32'hBBBB_0000;
         default: base = 32'hC000_0000 | (32'(r) << 16);
      endcase
      return base | (32'(wid) << 8) | 32'(t);
   endfunction

   function automatic logic [SlotW-1:0] exp_slot(input logic isreg, input logic [2:0] wid,
                                                  input logic [5:0] v);
      logic [SlotW-1:0] s;
      for (int t = 0; t < 32; t++) s[t*32 +: 32] = isreg ? rf_word(wid, v, t) : 32'(v);
      return s;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_slots(input logic [OpsW-1:0] act, input logic [OpsW-1:0] exp);
      for (int s = 0; s < 2; s++) begin
         int bad;
         bad = -1;
         n_chk++;
         for (int t = 31; t >= 0; t--)
            if (act[s*SlotW + t*32 +: 32] !== exp[s*SlotW + t*32 +: 32]) bad = t;
         if (bad >= 0) begin
            n_fail++;
            $display("FAIL eu_operands slot %0d thread %0d: got 0x%08h expected 0x%08h", s, bad,
                     act[s*SlotW + bad*32 +: 32], exp[s*SlotW + bad*32 +: 32]);
         end
      end
   endtask

   // ---------------- register file responder (1-cycle response) ----------------
   int stale_done_n = 0;
   bit pend = 1'b0;
   logic [2:0] pend_wid;
   logic [5:0] pend_reg;
   always @(negedge clk) begin
      rf_rsp_valid_i = 1'b0;
      if (stale_req_n != stale_done_n) begin
         stale_done_n++;
         rf_rsp_valid_i = 1'b1;
         rf_rsp_data_i  = {SlotW{1'b1}};
      end else if (pend) begin
         rf_rsp_valid_i = 1'b1;
         for (int t = 0; t < 32; t++) rf_rsp_data_i[t*32 +: 32] = rf_word(pend_wid, pend_reg, t);
         pend = 1'b0;
      end
      if (rf_auto && !rst && rf_req_valid_o && rf_req_ready_i) begin
         pend     = 1'b1;
         pend_wid = rf_req_wid_o;
         pend_reg = rf_req_reg_o;
         req_count++;
      end
   end

   // ---------------- EU monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (!rst && eu_valid_o && eu_ready_i) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_issue: got tag 0x%0h with no instruction expected", eu_tag_o);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("eu_tag", 64'(eu_tag_o), 64'(e.tag));
            chk("eu_pc", 64'(eu_pc_o), 64'(e.pc));
            chk("eu_act_mask", 64'(eu_act_mask_o), 64'(e.mask));
            chk("eu_inst", 64'(eu_inst_o), 64'(e.inst));
            chk("eu_dst", 64'(eu_dst_o), 64'(e.dst));
            chk("handshake", 64'(opc_eu_handshake_o), 64'd1);
            chk("handshake_tag", 64'(opc_eu_tag_o), 64'(e.tag));
            chk_slots(eu_operands_o, e.ops);
         end
      end
      if (!rst && opc_eu_handshake_o) hs_count++;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic dispatch(input logic [5:0] tag, input logic [31:0] pc, input logic [31:0] mask,
                           input logic [5:0] opc, input logic [5:0] dst, input logic [1:0] isreg,
                           input logic [5:0] op0, input logic [5:0] op1, input bit expect_issue);
      int   waited;
      exp_t e;
      waited = 0;
      while (!opc_ready_o && waited < 50) begin
         tick();
         waited++;
      end
      if (!opc_ready_o) begin
         n_chk++;
         n_fail++;
         $display("FAIL dispatch_timeout: got opc_ready_o=0 expected 1 within 50 cycles");
         return;
      end
      disp_valid_i           = 1'b1;
      disp_tag_i             = tag;
      disp_pc_i              = pc;
      disp_act_mask_i        = mask;
      disp_inst_i            = '{opcode: opc, fmt: 2'd1};
      disp_dst_i             = dst;
      disp_operands_is_reg_i = isreg;
      disp_operands_i        = {op1, op0};
      if (expect_issue) begin
         e.tag  = tag;
         e.pc   = pc;
         e.mask = mask;
         e.inst = '{opcode: opc, fmt: 2'd1};
         e.dst  = dst;
         e.ops  = {exp_slot(isreg[1], tag[2:0], op1), exp_slot(isreg[0], tag[2:0], op0)};
         exp_q.push_back(e);
      end
      tick();
      disp_valid_i = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got simulation time limit expected test completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed tests ----------------
   initial begin
      int hs0, rc0, wait_n;
      rst = 1'b1;
      disp_valid_i = 1'b0; disp_tag_i = '0; disp_pc_i = '0; disp_act_mask_i = '0;
      disp_inst_i = '0; disp_dst_i = '0; disp_operands_is_reg_i = '0; disp_operands_i = '0;
      rf_req_ready_i = 1'b1; rf_rsp_data_i = '0; eu_ready_i = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      tick();

      // reset / idle
      chk("rst_opc_ready", 64'(opc_ready_o), 64'd1);
      chk("rst_eu_valid", 64'(eu_valid_o), 64'd0);
      chk("rst_rf_req_valid", 64'(rf_req_valid_o), 64'd0);
      chk("rst_handshake", 64'(opc_eu_handshake_o), 64'd0);
      chk("rst_eu_tag", 64'(eu_tag_o), 64'd0);
      chk("rst_eu_operands", 64'(|eu_operands_o), 64'd0);

      // all-immediate: issue one cycle after dispatch
      dispatch(6'h13, 32'h0000_0100, 32'hFFFF_FFFF, 6'h01, 6'd10, 2'b00, 6'd5, 6'd9, 1'b1);
      chk("imm_eu_valid_c1", 64'(eu_valid_o), 64'd1);
      chk("imm_opc_ready_c1", 64'(opc_ready_o), 64'd0);
      tick();
      chk("imm_idle_c2", 64'(opc_ready_o), 64'd1);

      // two register operands, 1-cycle responses
      dispatch(6'h09, 32'h0000_0200, 32'h0000_FFFF, 6'h02, 6'd11, 2'b11, 6'd4, 6'd7, 1'b1);
      chk("rr_req_valid_c1", 64'(rf_req_valid_o), 64'd1);
      chk("rr_req_reg_c1", 64'(rf_req_reg_o), 64'd4);
      chk("rr_req_wid_c1", 64'(rf_req_wid_o), 64'd1);
      tick();
      chk("rr_req_valid_c2", 64'(rf_req_valid_o), 64'd0);
      tick();
      chk("rr_req_valid_c3", 64'(rf_req_valid_o), 64'd1);
      chk("rr_req_reg_c3", 64'(rf_req_reg_o), 64'd7);
      tick();
      chk("rr_eu_valid_c4", 64'(eu_valid_o), 64'd0);
      tick();
      chk("rr_eu_valid_c5", 64'(eu_valid_o), 64'd1);
      tick();

      // only operand 1 is a register; register file stalls for 3 cycles
      rf_req_ready_i = 1'b0;
      rc0 = req_count;
      dispatch(6'h22, 32'h0000_0300, 32'hF0F0_F0F0, 6'h03, 6'd12, 2'b10, 6'd3, 6'd12, 1'b1);
      for (int i = 0; i < 3; i++) begin
         chk("bp_req_valid", 64'(rf_req_valid_o), 64'd1);
         chk("bp_req_reg", 64'(rf_req_reg_o), 64'd12);
         chk("bp_req_wid", 64'(rf_req_wid_o), 64'd2);
         chk("bp_opc_ready", 64'(opc_ready_o), 64'd0);
         tick();
      end
      rf_req_ready_i = 1'b1;
      chk("bp_req_valid_c4", 64'(rf_req_valid_o), 64'd1);
      tick();
      chk("bp_req_valid_c5", 64'(rf_req_valid_o), 64'd0);
      chk("bp_opc_ready_c5", 64'(opc_ready_o), 64'd0);
      tick();
      chk("bp_eu_valid_c6", 64'(eu_valid_o), 64'd1);
      tick();
      chk("bp_req_count", 64'(req_count - rc0), 64'd1);

      // EU back-pressure for 4 cycles
      eu_ready_i = 1'b0;
      hs0 = hs_count;
      dispatch(6'h3D, 32'h0000_0400, 32'h8000_0001, 6'h04, 6'd63, 2'b00, 6'd63, 6'd0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         chk("eb_eu_valid", 64'(eu_valid_o), 64'd1);
         chk("eb_eu_tag", 64'(eu_tag_o), 64'h3D);
         chk("eb_eu_pc", 64'(eu_pc_o), 64'h400);
         chk("eb_eu_dst", 64'(eu_dst_o), 64'd63);
         chk("eb_eu_op0", 64'(eu_operands_o[31:0]), 64'd63);
         chk("eb_handshake", 64'(opc_eu_handshake_o), 64'd0);
         tick();
      end
      eu_ready_i = 1'b1;
      tick();
      chk("eb_single_pulse", 64'(hs_count - hs0), 64'd1);
      chk("eb_opc_ready_after", 64'(opc_ready_o), 64'd1);
      dispatch(6'h05, 32'h0000_0404, 32'h0000_0003, 6'h05, 6'd6, 2'b00, 6'd1, 6'd2, 1'b1);
      chk("eb_next_eu_valid", 64'(eu_valid_o), 64'd1);
      tick();

      // reset while a read is outstanding; its response arrives after reset
      rf_auto = 1'b0;
      hs0 = hs_count;
      dispatch(6'h0E, 32'h0000_0500, 32'hFFFF_0000, 6'h06, 6'd1, 2'b01, 6'd20, 6'd0, 1'b0);
      chk("rr_mid_req_valid", 64'(rf_req_valid_o), 64'd1);
      chk("rr_mid_req_reg", 64'(rf_req_reg_o), 64'd20);
      tick();
      chk("rr_mid_outstanding", 64'(rf_req_valid_o), 64'd0);
      rst = 1'b1;
      #1;
      chk("mid_rst_opc_ready", 64'(opc_ready_o), 64'd1);
      chk("mid_rst_rf_req_valid", 64'(rf_req_valid_o), 64'd0);
      chk("mid_rst_eu_tag", 64'(eu_tag_o), 64'd0);
      chk("mid_rst_rf_req_reg", 64'(rf_req_reg_o), 64'd0);
      tick();
      rst = 1'b0;
      stale_req_n++;
      rf_auto = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("stale_opc_ready", 64'(opc_ready_o), 64'd1);
         chk("stale_eu_valid", 64'(eu_valid_o), 64'd0);
         chk("stale_rf_req_valid", 64'(rf_req_valid_o), 64'd0);
      end
      chk("stale_no_handshake", 64'(hs_count - hs0), 64'd0);

      // recovery: one register operand after reset
      dispatch(6'h17, 32'h0000_0600, 32'h1234_5678, 6'h07, 6'd2, 2'b01, 6'd7, 6'd33, 1'b1);
      tick();
      tick();
      chk("rec_eu_valid_c3", 64'(eu_valid_o), 64'd1);

      wait_n = 0;
      while (exp_q.size() != 0 && wait_n < 20) begin
         tick();
         wait_n++;
      end
      chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
      chk("handshake_total", 64'(hs_count), 64'd6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/operand_collector.md
Name: operand_collector

Overview:
- Receiving end of the warp-dispatch interface.
- Accepts one dispatched instruction at a time from the multi-warp dispatcher, reads its register operands from the register file sequentially, then presents the complete instruction with operand data to the execution units.
- Reports the OPC→EU handshake, carrying the instruction's iid, back to the dispatcher so it can release operand dependencies.

Parameters:
- PcWidth, 32, program counter width
- NumWarps, 8, warps per compute unit
- WarpWidth, 32, threads per warp
- NumTags, 8, inflight tags per warp
- RegIdxWidth, 6, register index width
- OperandsPerInst, 2, operands per instruction
- RegWidth, 32, bits per thread register
- Derived, not overridable: TagWidth=$clog2(NumTags); WidWidth=NumWarps>1?$clog2(NumWarps):1; IidWidth=TagWidth+WidWidth

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, asynchronous, active-high
- opc_ready_o  out  1  ready to accept a dispatched instruction
- disp_valid_i  in  1  dispatched instruction valid
- disp_tag_i  in  IidWidth  iid = {tag, wid}; wid is the low WidWidth bits
- disp_pc_i  in  PcWidth  pc
- disp_act_mask_i  in  WarpWidth  active mask
- disp_inst_i  in  inst_t  instruction (bgpu_pkg)
- disp_dst_i  in  RegIdxWidth  destination register
- disp_operands_is_reg_i  in  OperandsPerInst  per-operand flag: 1 = register, 0 = immediate
- disp_operands_i  in  OperandsPerInst*RegIdxWidth  operand register index or immediate
- rf_req_valid_o  out  1  register read request
- rf_req_ready_i  in  1  register file accepts the request
- rf_req_wid_o  out  WidWidth  warp to read
- rf_req_reg_o  out  RegIdxWidth  register to read
- rf_rsp_valid_i  in  1  read data valid
- rf_rsp_data_i  in  WarpWidth*RegWidth  read data
- eu_valid_o  out  1  instruction ready for the EU
- eu_ready_i  in  1  EU accepts
- eu_tag_o, eu_pc_o, eu_act_mask_o, eu_inst_o, eu_dst_o  out  as disp_*  latched instruction fields
- eu_operands_o  out  OperandsPerInst*WarpWidth*RegWidth  collected operand data
- opc_eu_handshake_o  out  1  equals eu_valid_o & eu_ready_i
- opc_eu_tag_o  out  IidWidth  equals eu_tag_o

Behaviour:
- FSM states: IDLE, READ, ISSUE.
- Reset state: IDLE. All latched fields and operand data reset to 0; outstanding flag reset to 0.
- Reset values of outputs: opc_ready_o=1, all other outputs 0.
- opc_ready_o=1 only in IDLE; it has no combinational path from eu_ready_i.
- IDLE, on disp_valid_i:
  - Latch all disp_* fields.
  - Immediate operands: slot i = operand index zero-extended to RegWidth and replicated across all threads.
  - Go to READ if any is_reg bit is set, otherwise go to ISSUE.
- READ, operand walk:
  - Walk operands in index order 0..OperandsPerInst-1, skipping immediates.
  - While no read is outstanding: rf_req_valid_o=1, rf_req_wid_o=latched wid, rf_req_reg_o=current operand index.
  - On rf_req_valid_o & rf_req_ready_i: set outstanding; drop rf_req_valid_o the next cycle.
  - At most one read is outstanding. Response latency is ≥1 cycle after the request handshake; responses arrive in order.
- READ, on rf_rsp_valid_i with outstanding set:
  - Capture rf_rsp_data_i into the current slot; clear outstanding.
  - Advance to the next register operand, issuing its request the following cycle.
  - If it was the last register operand, go to ISSUE.
- rf_rsp_valid_i while not outstanding (including a stale response after reset) is ignored. A simulation assertion flags it.
- ISSUE:
  - eu_valid_o=1. eu_valid_o and all eu_* outputs stay stable until eu_ready_i; no retraction.
  - On eu_ready_i: pulse opc_eu_handshake_o with opc_eu_tag_o=eu_tag_o; go to IDLE the next cycle.
- Latency:
  - All-immediate instruction: eu_valid_o one cycle after the dispatch handshake.
  - Each register operand with rf_req_ready_i=1 and a 1-cycle response costs 2 cycles, plus 1 cycle to enter ISSUE.
- Back-pressure: rf_req_ready_i low holds rf_req_valid_o and the index stable. eu_ready_i low holds the FSM in ISSUE.
- Reset mid-operation (any state): the instruction is dropped; no handshake is emitted; outputs return to reset values asynchronously.

Test Plan:
- Reset, then idle -> opc_ready_o=1, eu_valid_o=0, rf_req_valid_o=0, opc_eu_handshake_o=0.
- Dispatch tag=0x13 (tag 2, wid 3), is_reg=2'b00, operands {5,9}, eu_ready_i=1 -> eu_valid_o at cycle 1; every thread of operand0=5 and operand1=9; opc_eu_handshake_o=1 with opc_eu_tag_o=0x13.
- Dispatch wid 1, is_reg=2'b11, regs {4,7}, RF ready with 1-cycle response (data 0xA…, 0xB…) -> requests reg 4 at cycle 1 and reg 7 at cycle 3, rf_req_wid_o=1; eu_valid_o at cycle 5 with slots A, B.
- is_reg=2'b10, rf_req_ready_i low for 3 cycles -> only operand1 is read; request held stable for 3 cycles; opc_ready_o=0 throughout.
- eu_ready_i low for 4 cycles in ISSUE -> eu_* outputs stable; single opc_eu_handshake_o pulse; next dispatch accepted the cycle after.
- Assert rst_i while in READ with a read outstanding; the late rf_rsp_valid_i arrives after reset -> response ignored; state IDLE; no eu_valid_o or handshake.
